vec_stream_tx: RTL and testbench
================================

Name: vec_stream_tx

Overview:
- Transmit side of the valid/ready vector stream that the fc layers consume.
- Holds one N-element signed vector, loaded by a host write port.
- On `start`, streams the vector over output_valid/output_ready/output_data `num_vec` times back-to-back, element 0 first.
- Drives the input port of an fc layer in system bring-up and in layer-chaining benches.

Parameters:
- WIDTH, 16, data word width in bits (signed).
- N, 8, vector length (elements per transmission); N >= 2.
- LOGN, $clog2(N), element address width (localparam).
- MAXREP, 15, maximum repeat count; sets the num_vec width to $clog2(MAXREP+1).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe for the vector buffer; honoured only in IDLE.
- wr_addr  in  LOGN  element index to write.
- wr_data  in  WIDTH  element value.
- start  in  1  single-cycle request to begin transmission; honoured only in IDLE.
- num_vec  in  $clog2(MAXREP+1)  repeat count, sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last element handshakes.
- output_valid  out  1  stream valid.
- output_ready  in  1  stream ready from the consumer.
- output_data  out  WIDTH  stream data (signed).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, output_valid=0, output_data=0; counters and skid buffer cleared. Buffer contents are not reset (undefined until written).
- Buffer: N x WIDTH, synchronous read with 1-cycle latency, write-first not required.
  - wr_en with addr >= N is ignored.
  - wr_en outside IDLE is ignored.
- IDLE: start=1 latches num_vec and clears the element index e and repeat index r.
  - num_vec==0: go to FINISH directly, no output beats.
  - otherwise: go to STREAM.
- STREAM: issues buffer reads for element e of repeat r into a 2-entry output skid FIFO. output_valid and output_data come only from registers (no combinational path from output_ready).
  - A read is issued only if skid occupancy plus reads in flight is less than 2.
  - After each read, e increments. At e==N-1, e wraps to 0 and r increments.
  - Once the last read (e=N-1, r=num_vec-1) is issued, no further reads.
- Latency: start sampled at edge T → output_valid=1 after edge T+2, carrying element 0.
- Throughput: with output_ready held at 1, one beat per cycle with no bubbles, including across repeat boundaries.
- Handshake: a beat transfers when output_valid && output_ready.
  - While output_valid=1 and output_ready=0, output_data and output_valid are held stable.
  - output_valid never drops without a transfer.
- Beat count is exactly N*num_vec. When the final beat transfers, go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
  - start in FINISH is ignored.
  - start in the first IDLE cycle is accepted.
- start while busy is ignored; num_vec is not re-sampled.
- reset asserted mid-stream aborts immediately: output_valid=0 asynchronously, no done pulse.

Decomposition:
- Package vec_stream_tx_pkg: state enum (IDLE, STREAM, FINISH) and default WIDTH/N constants.
- Buffer: the existing `memory` module, with an inverted reset not needed (it has no reset).
- One sub-module, vec_stream_tx_skid: 2-entry registered FIFO with valid/ready out, push in, and an occupancy output used for read throttling.

Test Plan:
- Load elements {1,-2,3,-4,5,-6,7,-8}, start with num_vec=1, output_ready held at 1 → valid first high 2 cycles after start; 8 consecutive beats 1,-2,...,-8; done pulses the cycle after beat 8; busy low again.
- Same vector, num_vec=3, output_ready=1 → 24 beats with no bubble between -8 and the next 1; exactly one done pulse.
- num_vec=2 with output_ready random (50%) and stalls of 5 cycles → data stable during every stall; sequence 1..-8 twice with no loss or duplication.
- num_vec=0 → no output_valid; done pulse 1 cycle after start.
- Mid-stream (after 3 beats): wr_en to addr 0 with 99, plus a second start → ignored, remaining beats unchanged; later IDLE write then start → first beat is 99.
- reset driven low for 1 cycle after beat 4 of an 8-beat run → output_valid=0 immediately, no done; the next start replays from element 0.

Source files
------------

// File: rtl/vec_stream_tx_pkg.sv
// Shared types and default sizing for the vector stream transmitter.
package vec_stream_tx_pkg;

  localparam int unsigned VST_WIDTH  = 16;
  localparam int unsigned VST_N      = 8;
  localparam int unsigned VST_MAXREP = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Range test done in 32-bit space so it stays meaningful for any depth.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/memory.sv
// Simple dual-port buffer: registered write, synchronous read with one cycle latency.
module memory #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/vec_stream_tx_skid.sv
// Two-entry registered FIFO feeding the stream port; valid/data come straight from the head registers.
module vec_stream_tx_skid
  import vec_stream_tx_pkg::*;
#(
  parameter int unsigned WIDTH = VST_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [1:0]       occ_c
);

  logic             tail_valid;
  logic [WIDTH-1:0] tail_data;
  logic             pop_c;

  assign pop_c = valid && ready;
  assign occ_c = 2'(valid) + 2'(tail_valid);

  // Pushes never arrive when both entries are full and nothing pops; the producer throttles on occ_c.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid      <= 1'b0;
      data       <= '0;
      tail_valid <= 1'b0;
      tail_data  <= '0;
    end else if (pop_c) begin
      if (tail_valid) begin
        data       <= tail_data;
        tail_valid <= push;
        if (push) begin
          tail_data <= push_data;
        end
      end else begin
        valid <= push;
        if (push) begin
          data <= push_data;
        end
      end
    end else if (push) begin
      if (!valid) begin
        valid <= 1'b1;
        data  <= push_data;
      end else begin
        tail_valid <= 1'b1;
        tail_data  <= push_data;
      end
    end
  end

endmodule

// File: rtl/vec_stream_tx.sv
// Streams a host-loaded N-element vector num_vec times over a valid/ready port.
module vec_stream_tx
  import vec_stream_tx_pkg::*;
#(
  parameter int unsigned WIDTH  = VST_WIDTH,
  parameter int unsigned N      = VST_N,
  parameter int unsigned MAXREP = VST_MAXREP,
  localparam int unsigned LOGN  = $clog2(N),
  localparam int unsigned NVW   = $clog2(MAXREP + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [LOGN-1:0]         wr_addr,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic                    start,
  input  logic [NVW-1:0]          num_vec,
  output logic                    busy,
  output logic                    done,
  output logic                    output_valid,
  input  logic                    output_ready,
  output logic signed [WIDTH-1:0] output_data
);

  state_t           state, state_next;
  logic [LOGN-1:0]  elem_idx;
  logic [NVW-1:0]   rep_idx;
  logic [NVW-1:0]   rep_total;
  logic             reads_done;
  logic             in_flight;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] skid_data;
  logic [1:0]       occ_c;
  logic [1:0]       room_c;
  logic             wr_ok_c;
  logic             rd_en_c;
  logic             pop_c;
  logic             last_beat_c;

  assign wr_ok_c = wr_en && (state == IDLE) && addr_in_range(32'(wr_addr), N);
  assign pop_c   = output_valid && output_ready;

  // Credit counts the entry freed by this cycle's pop so a steady ready stream sees no bubbles.
  assign room_c  = occ_c - 2'(pop_c) + 2'(in_flight);
  assign rd_en_c = (state == STREAM) && !reads_done && (room_c < 2'd2);

  assign last_beat_c = reads_done && !in_flight && pop_c && (occ_c == 2'd1);

  memory #(
    .WIDTH (WIDTH),
    .DEPTH (N),
    .AW    (LOGN)
  ) u_buf (
    .clk   (clk),
    .we    (wr_ok_c),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_en_c),
    .raddr (elem_idx),
    .rdata (rd_data)
  );

  vec_stream_tx_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (in_flight),
    .push_data (rd_data),
    .ready     (output_ready),
    .valid     (output_valid),
    .data      (skid_data),
    .occ_c     (occ_c)
  );

  assign output_data = skid_data;

  // State register plus registered status outputs derived from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == STREAM);
      done  <= (state_next == FINISH);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (num_vec == '0) ? FINISH : STREAM;
        end
      end
      STREAM: begin
        if (last_beat_c) begin
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read sequencer: element index inner loop, repeat index outer loop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      elem_idx   <= '0;
      rep_idx    <= '0;
      rep_total  <= '0;
      reads_done <= 1'b0;
      in_flight  <= 1'b0;
    end else begin
      in_flight <= rd_en_c;
      if ((state == IDLE) && start) begin
        elem_idx   <= '0;
        rep_idx    <= '0;
        rep_total  <= num_vec;
        reads_done <= 1'b0;
      end else if (rd_en_c) begin
        if (elem_idx == LOGN'(N - 1)) begin
          elem_idx <= '0;
          if (rep_idx == rep_total - NVW'(1)) begin
            reads_done <= 1'b1;
          end else begin
            rep_idx <= rep_idx + NVW'(1);
          end
        end else begin
          elem_idx <= elem_idx + LOGN'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_stream_tx.sv
// Randomized bench for vec_stream_tx against a queue-based model of the expected beat stream.
module tb_vec_stream_tx;

  localparam int W   = 16;
  localparam int NE  = 8;
  localparam int NVW = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                wr_en;
  logic [2:0]          wr_addr;
  logic signed [W-1:0] wr_data;
  logic                start;
  logic [NVW-1:0]      num_vec;
  logic                busy;
  logic                done;
  logic                output_valid;
  logic                output_ready;
  logic signed [W-1:0] output_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic signed [W-1:0] mem_m [NE];
  logic signed [W-1:0] exp_q [$];
  logic signed [W-1:0] seen_q [$];
  logic signed [W-1:0] prev_data;
  bit  m_running   = 1'b0;
  bit  m_done_next = 1'b0;
  bit  m_first     = 1'b0;
  bit  prev_stall  = 1'b0;
  int  neg_cnt     = 0;
  int  start_neg   = 0;
  int  done_cnt    = 0;
  int  hs_first    = 0;
  int  hs_last     = 0;
  int  ready_mode  = 0;
  int  stall_left  = 0;

  vec_stream_tx dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .num_vec      (num_vec),
    .busy         (busy),
    .done         (done),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: outputs are sampled on the falling edge, i.e. the values the next rising edge sees.
  initial begin
    bit exp_done;
    bit idle;
    int nv;
    forever begin
      @(negedge clk);
      neg_cnt++;
      if (!reset) begin
        check("rst_valid", output_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        exp_q.delete();
        m_running   = 1'b0;
        m_done_next = 1'b0;
        m_first     = 1'b0;
        prev_stall  = 1'b0;
      end else begin
        exp_done    = m_done_next;
        m_done_next = 1'b0;
        check("done", done, exp_done);
        check("busy", busy, m_running);
        if (done) done_cnt++;
        if (prev_stall) begin
          check("stall_valid", output_valid, 1);
          check("stall_data", output_data, prev_data);
        end
        if (output_valid) begin
          if (m_first) begin
            check("latency", neg_cnt - start_neg, 3);
            m_first = 1'b0;
          end
          if (exp_q.size() == 0) begin
            check("spurious_valid", output_valid, 0);
          end else begin
            check("data", output_data, exp_q[0]);
            if (output_ready) begin
              if (seen_q.size() == 0) hs_first = neg_cnt;
              hs_last = neg_cnt;
              seen_q.push_back(output_data);
              void'(exp_q.pop_front());
              if (exp_q.size() == 0 && m_running) begin
                m_running   = 1'b0;
                m_done_next = 1'b1;
              end
            end
          end
        end
        prev_stall = output_valid && !output_ready;
        prev_data  = output_data;
        idle = !m_running && !exp_done;
        if (idle && wr_en) mem_m[wr_addr] = wr_data;
        if (idle && start) begin
          nv = int'(num_vec);
          for (int r = 0; r < nv; r++)
            for (int e = 0; e < NE; e++)
              exp_q.push_back(mem_m[e]);
          if (nv == 0) begin
            m_done_next = 1'b1;
          end else begin
            m_running = 1'b1;
            m_first   = 1'b1;
            start_neg = neg_cnt;
          end
        end
      end
    end
  end

  // Consumer ready: held high, or random with occasional 5-cycle stalls.
  initial begin
    output_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        output_ready = 1'b1;
      end else if (stall_left > 0) begin
        output_ready = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 9) == 0) begin
        output_ready = 1'b0;
        stall_left   = 4;
      end else begin
        output_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  task automatic write_elem(input int a, input int d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = 3'(a); wr_data = 16'(d);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input int nv);
    @(posedge clk); #1;
    start = 1'b1; num_vec = 4'(nv);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while ((m_running || m_done_next) && k < budget) begin
      @(posedge clk);
      k++;
    end
    check({name, "_idle_reached"}, (m_running || m_done_next), 0);
  endtask

  task automatic wait_seen(input int n, input int budget, input string name);
    int k = 0;
    while (seen_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check({name, "_beats_reached"}, seen_q.size(), n);
  endtask

  task automatic clear_log();
    seen_q.delete();
    done_cnt = 0;
  endtask

  initial begin
    int base_vec [NE];
    int nv;
    base_vec = '{1, -2, 3, -4, 5, -6, 7, -8};
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; num_vec = '0;
    for (int i = 0; i < NE; i++) mem_m[i] = '0;
    #1;
    check("reset_valid_t0", output_valid, 0);
    check("reset_data_t0", output_data, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < NE; i++) write_elem(i, base_vec[i]);

    // Single pass, ready held high
    ready_mode = 0;
    clear_log();
    pulse_start(1);
    wait_idle(100, "t1");
    check("t1_count", seen_q.size(), 8);
    check("t1_first", seen_q[0], 1);
    check("t1_second", seen_q[1], -2);
    check("t1_last", seen_q[7], -8);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_busy_after", busy, 0);

    // Three passes back-to-back, no bubbles
    clear_log();
    pulse_start(3);
    wait_idle(200, "t2");
    check("t2_count", seen_q.size(), 24);
    check("t2_wrap", seen_q[8], 1);
    check("t2_span", hs_last - hs_first, 23);
    check("t2_done_cnt", done_cnt, 1);

    // Two passes with random backpressure
    ready_mode = 1;
    clear_log();
    pulse_start(2);
    wait_idle(1000, "t3");
    check("t3_count", seen_q.size(), 16);
    check("t3_wrap", seen_q[8], 1);
    check("t3_last", seen_q[15], -8);
    ready_mode = 0;

    // Zero repeat count
    clear_log();
    pulse_start(0);
    wait_idle(20, "t4");
    repeat (3) @(posedge clk);
    check("t4_count", seen_q.size(), 0);
    check("t4_done_cnt", done_cnt, 1);

    // Write and restart while busy are ignored
    clear_log();
    pulse_start(1);
    wait_seen(3, 50, "t5");
    #1;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'sd99; start = 1'b1; num_vec = 4'd5;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0;
    wait_idle(100, "t5");
    check("t5_count", seen_q.size(), 8);
    check("t5_beat3", seen_q[3], -4);
    check("t5_done_cnt", done_cnt, 1);
    write_elem(0, 99);
    clear_log();
    pulse_start(1);
    wait_idle(100, "t5b");
    check("t5b_first", seen_q[0], 99);
    check("t5b_count", seen_q.size(), 8);

    // Reset mid-stream aborts without done, then replays from element 0
    clear_log();
    pulse_start(1);
    wait_seen(4, 50, "t6");
    #1 reset = 1'b0;
    #1;
    check("t6_async_valid", output_valid, 0);
    check("t6_async_busy", busy, 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    check("t6_no_done", done_cnt, 0);
    clear_log();
    pulse_start(1);
    wait_idle(100, "t6b");
    check("t6b_first", seen_q[0], 99);
    check("t6b_count", seen_q.size(), 8);

    // Random vectors, repeat counts and backpressure
    ready_mode = 1;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < NE; i++) write_elem(i, int'($urandom_range(0, 65535)) - 32768);
      nv = int'($urandom_range(1, 4));
      clear_log();
      pulse_start(nv);
      wait_idle(2000, "rand");
      check("rand_count", seen_q.size(), 8 * nv);
      check("rand_done_cnt", done_cnt, 1);
    end
    ready_mode = 0;
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
